// File: rtl/led_bar_level_encoder.sv
// Thermometer LED-bar to level encoder: 2-FF sync, debounce, validate, encode.
// i_level_bar in; o_level (0..4), o_valid change strobe, o_error illegal code.
module led_bar_level_encoder #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_level_bar,
  output logic [2:0] o_level,
  output logic       o_valid,
  output logic       o_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       meta;
  logic [3:0]       sync;

  state_t           state;
  state_t           state_nx;
  logic [3:0]       cand;
  logic [3:0]       cand_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  logic             code_ok;
  logic [2:0]       code_lvl;

  logic [2:0]       lvl_nx;
  logic             valid_nx;
  logic             err_nx;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta <= 4'b0000;
      sync <= 4'b0000;
    end else begin
      meta <= i_level_bar;
      sync <= meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cand  <= 4'b0000;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (sync != cand) begin
          cand_nx  = sync;
          cnt_nx   = '0;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (sync != cand) begin
          cand_nx = sync;
          cnt_nx  = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = COMMIT;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      COMMIT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    code_ok  = 1'b1;
    code_lvl = 3'd0;
    unique case (1'b1)
      (cand == 4'b0000): code_lvl = 3'd0;
      (cand == 4'b0001): code_lvl = 3'd1;
      (cand == 4'b0011): code_lvl = 3'd2;
      (cand == 4'b0111): code_lvl = 3'd3;
      (cand == 4'b1111): code_lvl = 3'd4;
      default:           code_ok  = 1'b0;
    endcase
  end

  // Level holds on an illegal code; the strobe
  // fires only when the committed value moves.
  always_comb begin
    lvl_nx   = o_level;
    valid_nx = 1'b0;
    err_nx   = o_error;
    if (state == COMMIT) begin
      if (code_ok) begin
        err_nx = 1'b0;
        if (code_lvl != o_level) begin
          lvl_nx   = code_lvl;
          valid_nx = 1'b1;
        end
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_level <= 3'd0;
      o_valid <= 1'b0;
      o_error <= 1'b0;
    end else begin
      o_level <= lvl_nx;
      o_valid <= valid_nx;
      o_error <= err_nx;
    end
  end

endmodule

// File: tb/tb_led_bar_level_encoder.sv
// Directed bench for led_bar_level_encoder with a short debounce window.
// Table of bar steps plus bounce, glitch and reset corner sequences.
module tb_led_bar_level_encoder;

  localparam int DEB = 4;
  localparam int CW  = 3;
  // Change lands just after an edge; the next edge samples it,
  // and outputs move DEB+3 edges after that one.
  localparam int TICKS = DEB + 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] bar;
  logic [2:0] level;
  logic       valid;
  logic       error;

  int n_vec;
  int n_err;

  logic [2:0] m_lvl;
  logic       m_err;

  typedef struct {
    logic [3:0] bar;
    logic [2:0] lvl;
    logic       err;
    logic       pulse;
  } vec_t;

  vec_t tbl [9];

  led_bar_level_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_level_bar(bar),
    .o_level    (level),
    .o_valid    (valid),
    .o_error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      name,
    input logic [2:0] lvl,
    input logic       err,
    input logic       vld
  );
    n_vec++;
    if (level !== lvl || error !== err || valid !== vld) begin
      n_err++;
      $display("FAIL %s: level=%0d error=%b valid=%b, want level=%0d error=%b valid=%b",
               name, level, error, valid, lvl, err, vld);
    end
  endtask

  task automatic run_latency(
    input string      name,
    input logic [2:0] lvl,
    input logic       err,
    input logic       pulse
  );
    for (int i = 1; i < TICKS; i++) begin
      tick();
      chk({name, "_wait"}, m_lvl, m_err, 1'b0);
    end
    tick();
    chk({name, "_commit"}, lvl, err, pulse);
    tick();
    chk({name, "_after"}, lvl, err, 1'b0);
    m_lvl = lvl;
    m_err = err;
  endtask

  task automatic apply(input int idx);
    bar = tbl[idx].bar;
    run_latency($sformatf("vec%0d", idx),
                tbl[idx].lvl, tbl[idx].err, tbl[idx].pulse);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_lvl = 3'd0;
    m_err = 1'b0;

    tbl[0] = '{4'b0011, 3'd2, 1'b0, 1'b1};
    tbl[1] = '{4'b1111, 3'd4, 1'b0, 1'b1};
    tbl[2] = '{4'b0101, 3'd2, 1'b1, 1'b0};
    tbl[3] = '{4'b0000, 3'd0, 1'b0, 1'b1};
    tbl[4] = '{4'b1111, 3'd4, 1'b0, 1'b1};
    tbl[5] = '{4'b0001, 3'd1, 1'b0, 1'b1};
    tbl[6] = '{4'b1001, 3'd1, 1'b1, 1'b0};
    tbl[7] = '{4'b0001, 3'd1, 1'b0, 1'b0};
    tbl[8] = '{4'b0011, 3'd2, 1'b0, 1'b1};

    rst_n = 1'b0;
    bar   = 4'b0111;
    tick();
    tick();
    chk("reset", 3'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    run_latency("boot", 3'd3, 1'b0, 1'b1);

    apply(0);
    apply(1);

    for (int k = 0; k < 9; k++) begin
      bar = (k % 2 == 0) ? 4'b0001 : 4'b0011;
      tick();
      chk("bounce", m_lvl, m_err, 1'b0);
      tick();
      chk("bounce", m_lvl, m_err, 1'b0);
    end
    bar = 4'b0011;
    run_latency("bounce_hold", 3'd2, 1'b0, 1'b1);

    for (int i = 2; i < 9; i++) apply(i);

    bar = 4'b0111;
    tick();
    chk("glitch", 3'd2, 1'b0, 1'b0);
    tick();
    chk("glitch", 3'd2, 1'b0, 1'b0);
    bar = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_back", 3'd2, 1'b0, 1'b0);
    end

    bar = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pre_reset", 3'd2, 1'b0, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 3'd0, 1'b0, 1'b0);
    m_lvl = 3'd0;
    m_err = 1'b0;
    tick();
    tick();
    chk("in_reset", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_latency("reacquire", 3'd4, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
